dmem_access_ctrl: RTL and testbench



---
 rtl/dmem_access_ctrl_pkg.sv | 14 +
 rtl/dmem_access_ctrl_if.sv | 24 ++
 rtl/dmem_timeout_ctr.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 102 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge data-memory port; master = access controller, slave = memory.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Busy-cycle counter with synchronous clear/enable; expired marks the cycle
// in which the count reaches TIMEOUT.
module dmem_timeout_ctr
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign count_next = count_reg + 1'b1;
  assign expired    = en & (count_next == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM loads/stores onto a variable-latency req/ack memory port,
// stalling the pipeline while an access is outstanding.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  dmem_access_ctrl_if.master mem,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o
);

  state_e            state_reg;
  state_e            state_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic access_req;
  logic accept;
  logic busy;
  logic cnt_expired;
  logic timed_out;

  assign access_req = MemRead_i | MemWrite_i;
  assign accept     = (state_reg == IDLE) & access_req;
  assign busy       = (state_reg == BUSY);
  // An ack arriving in the expiry cycle still completes the access.
  assign timed_out  = busy & ~mem.mem_ack & cnt_expired;

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (accept),
    .en      (busy),
    .expired (cnt_expired)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (access_req) state_next = BUSY;
      BUSY: begin
        if (mem.mem_ack)      state_next = DONE;
        else if (cnt_expired) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= MemWrite_i;
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
      end
      if (busy && mem.mem_ack && !we_reg) begin
        rdata_reg <= mem.mem_rdata;
      end
      if (timed_out) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = busy;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;

  assign stall_o       = accept | busy;
  assign rdata_o       = rdata_reg;
  assign rdata_valid_o = (state_reg == DONE) | (state_reg == ERR);
  assign err_o         = err_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl: a transaction-level timeline model
// predicts every output each cycle, with literal pins on the directed cases.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;

  dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  dmem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .MemRead_i     (MemRead_i),
    .MemWrite_i    (MemWrite_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .mem           (mem_bus),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  // Model state: what the controller has latched / reported so far.
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;

  // Per-cycle expectations
  logic        exp_stall, exp_req, exp_valid, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  bit          check_en = 1'b0;

  // Literal pins evaluated in the completion cycle of a directed access
  bit          pin_en = 1'b0;
  int          pin_req, pin_stall;
  logic [31:0] pin_rdata;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, at the falling edge
  initial begin
    int  req_run   = 0;
    int  stall_run = 0;
    bit  prev_req   = 1'b0;
    bit  prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req === 1'b1) begin
        if (!prev_req) req_run = 0;
        req_run++;
      end
      if (stall_o === 1'b1) begin
        if (!prev_stall) stall_run = 0;
        stall_run++;
      end
      prev_req   = (mem_bus.mem_req === 1'b1);
      prev_stall = (stall_o === 1'b1);
      if (check_en) begin
        chk("stall", 32'(stall_o), 32'(exp_stall));
        chk("mem_req", 32'(mem_bus.mem_req), 32'(exp_req));
        chk("mem_we", 32'(mem_bus.mem_we), 32'(exp_we));
        chk("mem_addr", mem_bus.mem_addr, exp_addr);
        chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
        chk("rdata", rdata_o, exp_rdata);
        chk("rdata_valid", 32'(rdata_valid_o), 32'(exp_valid));
        chk("err", 32'(err_o), 32'(exp_err));
      end
      if (pin_en) begin
        chk("pin_req_cycles", 32'(req_run), 32'(pin_req));
        chk("pin_stall_cycles", 32'(stall_run), 32'(pin_stall));
        chk("pin_rdata", rdata_o, pin_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit stall, input bit req, input bit valid);
    exp_stall = stall;
    exp_req   = req;
    exp_valid = valid;
    exp_we    = m_we;
    exp_addr  = m_addr;
    exp_wdata = m_wdata;
    exp_rdata = m_rdata;
    exp_err   = m_err;
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic idle_cycle();
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = $urandom;
    wdata_i    = $urandom;
    mem_bus.mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
  endtask

  // One access issued from IDLE; the memory acks in BUSY cycle k (k > TO never acks).
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input int k, input logic [31:0] rdv,
                           input bit pin, input int p_req, input int p_stall,
                           input logic [31:0] p_rdata);
    bit acked;
    int n;
    acked = (k <= TO);
    n     = acked ? k : TO;
    txn_no++;
    $display("txn %0d: rd=%0d wr=%0d addr=0x%08h wdata=0x%08h ack_cycle=%0d %s",
             txn_no, rd, wr, a, d, k, acked ? "ack" : "timeout");
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    mem_bus.mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    m_we    = wr;
    m_addr  = a;
    m_wdata = d;
    for (int i = 1; i <= n; i++) begin
      mem_bus.mem_ack   = acked && (i == k);
      mem_bus.mem_rdata = (acked && i == k) ? rdv : $urandom;
      set_exp(1'b1, 1'b1, 1'b0);
      step();
    end
    if (acked) begin
      if (!m_we) m_rdata = rdv;
    end else begin
      m_rdata = '0;
      m_err   = 1'b1;
    end
    mem_bus.mem_ack   = 1'($urandom_range(0, 1));
    mem_bus.mem_rdata = $urandom;
    set_exp(1'b0, 1'b0, 1'b1);
    pin_en    = pin;
    pin_req   = p_req;
    pin_stall = p_stall;
    pin_rdata = p_rdata;
    step();
    pin_en = 1'b0;
  endtask

  task automatic random_traffic(input int count);
    int op;
    for (int t = 0; t < count; t++) begin
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, $urandom, $urandom, $urandom_range(1, TO + 2),
                $urandom, 1'b0, 0, 0, '0);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = '0;
    wdata_i    = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    model_reset();
    step();
    step();
    check_en = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    rst_i = 1'b0;
    idle_cycle();

    // Load, ack in 3rd BUSY cycle
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b1, 3, 4, 32'hDEADBEEF);
    idle_cycle();
    // Store, immediate ack; read data untouched
    do_access(1'b0, 1'b1, 32'h80, 32'h12345678, 1, 32'h0BAD0BAD, 1'b1, 1, 2, 32'hDEADBEEF);
    idle_cycle();
    // Back-to-back load then store
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'hA5A5A5A5, 1'b1, 2, 3, 32'hA5A5A5A5);
    do_access(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1, 32'h11111111, 1'b1, 1, 2, 32'hA5A5A5A5);
    // Read and write together issue as a write
    do_access(1'b1, 1'b1, 32'h200, 32'h0F0F0F0F, 2, 32'h22222222, 1'b1, 2, 3, 32'hA5A5A5A5);
    // Ack in the TIMEOUT-th cycle beats the timeout
    do_access(1'b1, 1'b0, 32'h300, 32'h0, TO, 32'h5A5A5A5A, 1'b1, TO, TO + 1, 32'h5A5A5A5A);
    idle_cycle();
    // No ack: abandoned after TIMEOUT busy cycles, error sticks
    do_access(1'b1, 1'b0, 32'h400, 32'h0, TO + 1, 32'h0, 1'b1, TO, TO + 1, 32'h0);
    idle_cycle();
    idle_cycle();

    random_traffic(50);

    // Reset in the 2nd BUSY cycle, then a late ack
    $display("txn reset: load to 0x500 aborted by reset in BUSY cycle 2");
    MemRead_i  = 1'b1;
    MemWrite_i = 1'b0;
    addr_i     = 32'h500;
    wdata_i    = 32'h77777777;
    mem_bus.mem_ack = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    m_we = 1'b0; m_addr = 32'h500; m_wdata = 32'h77777777;
    set_exp(1'b1, 1'b1, 1'b0);
    step();
    rst_i = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0);
    step();
    rst_i      = 1'b0;
    MemRead_i  = 1'b0;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h99999999;
    model_reset();
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    set_exp(1'b0, 1'b0, 1'b0);
    step();
    idle_cycle();

    random_traffic(40);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
